spi_xfer_ctrl: RTL and testbench
================================

Name: spi_xfer_ctrl

Overview:
Transfer sequencer sitting directly upstream of the SPI byte engine (spi_master). It buffers bytes written by the AXI4-Lite register bank in a TX FIFO and issues them one at a time to the byte engine. Each received byte is pushed into an RX FIFO. It also owns the slave-select line, holding it asserted across a whole burst with programmable setup and hold delays.

Parameters:
FIFO_DEPTH, 8, entries per TX and RX FIFO; power of 2, >=2
CS_SETUP_CYC, 50, clk cycles ss_n is low before the first start of a burst; >=1
CS_HOLD_CYC, 50, clk cycles ss_n stays low after the last done of a burst; >=1
LW, $clog2(FIFO_DEPTH)+1, level counter width (derived)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  level; permits bursts to start or continue
cs_keep  in  1  level; keep ss_n low while waiting for more TX data
tx_wr_en  in  1  push tx_wr_data into TX FIFO
tx_wr_data  in  8  byte to transmit
tx_full  out  1  TX FIFO full
tx_level  out  LW  TX FIFO occupancy
rx_rd_en  in  1  pop RX FIFO head
rx_rd_data  out  8  RX FIFO head (first-word fall-through); 8'h00 when empty
rx_empty  out  1  RX FIFO empty
rx_level  out  LW  RX FIFO occupancy
err_clr  in  1  pulse; clears sticky error flags
tx_overflow  out  1  sticky; write attempted while full
rx_overflow  out  1  sticky; received byte dropped because RX full
busy  out  1  high in every state except IDLE
ss_n  out  1  slave select, active-low
m_start  out  1  1-cycle start pulse to byte engine
m_tx_data  out  8  byte to byte engine, valid with m_start
m_tx_ready  in  1  byte engine idle
m_rx_data  in  8  byte from byte engine
m_done  in  1  1-cycle pulse at end of byte

Behaviour:
- Reset (async): both FIFOs empty, levels 0, flags 0, ss_n=1, m_start=0, busy=0, state IDLE. Reset mid-burst abandons everything. The byte engine shares the same reset.
- FIFO full/empty decisions use the pre-edge level. A write when tx_full is dropped and sets tx_overflow, even if a pop happens in the same cycle. A read when rx_empty is ignored. Simultaneous push and pop on a non-full, non-empty FIFO leaves the level unchanged. Pointers wrap modulo FIFO_DEPTH.
- err_clr clears both flags. If a flag sets in the same cycle as err_clr, set wins.
- m_tx_data is driven from the TX FIFO head combinationally.
- FSM:
  - IDLE: ss_n=1. Go to SETUP when enable=1 and TX not empty.
  - SETUP: ss_n=0. Count CS_SETUP_CYC cycles, then go to ISSUE.
  - ISSUE: ss_n=0. When m_tx_ready=1, assert m_start for exactly one cycle, pop TX FIFO in the same cycle, go to WAIT.
  - WAIT: ss_n=0. On m_done, push m_rx_data into RX FIFO (if RX is full: drop and set rx_overflow). Then:
    - enable=1 and TX not empty (level after pop) -> ISSUE; next m_start no earlier than the following cycle.
    - else enable=1 and cs_keep=1 -> PARK.
    - else -> HOLD.
  - PARK: ss_n=0. Go to ISSUE when enable=1 and TX not empty. Go to HOLD when cs_keep=0 or enable=0.
  - HOLD: ss_n=0. Count CS_HOLD_CYC cycles, then go to IDLE; ss_n=1 from the IDLE cycle on.
- enable dropped mid-byte: the current byte completes and its RX push still happens, then HOLD. Remaining TX data is retained.
- ss_n never toggles between consecutive bytes of a burst.
- m_start is never asserted outside ISSUE or while m_tx_ready=0.
- TX writes are accepted in every state, so a burst may be extended while it runs.

Test Plan:
- Loopback (miso=mosi), enable=1, cs_keep=0; write A5, 3C, FF -> RX reads A5, 3C, FF in order. Exactly 3 m_start pulses. ss_n low once, for CS_SETUP_CYC + 3 bytes + CS_HOLD_CYC cycles. tx_level returns to 0.
- enable=0; write 9 bytes 00..08 -> tx_full=1 after the 8th, tx_level=8, tx_overflow=1. Then enable=1 -> RX receives 00..07 only. err_clr -> tx_overflow=0.
- Loopback, 9 bytes, no RX reads -> rx_level=8, rx_overflow=1, RX holds 00..07. Pop once -> rx_level=7, rx_rd_data=01.
- cs_keep=1; write 11, wait 2000 cycles, write 22 -> ss_n stays low throughout and never rises. Clear cs_keep -> ss_n rises CS_HOLD_CYC cycles later.
- Deassert enable during byte 2 of a 4-byte burst -> byte 2 completes and lands in RX, then HOLD, then IDLE with tx_level=2. Re-enable -> a new SETUP, then bytes 3 and 4 sent.
- Assert reset during WAIT -> ss_n=1, m_start=0, all levels 0, busy=0 immediately. After release, no m_start until a new write.

Source files
------------

// File: rtl/spi_xfer_ctrl.sv
// SPI burst sequencer: TX/RX byte FIFOs feeding the byte engine, owns ss_n across a burst.
// m_start is same-cycle from ISSUE state plus m_tx_ready; writes to a full TX and pushes to a full RX are dropped and flagged.

module spi_xfer_ctrl_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign level    = level_q;
    assign head_dat = empty ? '0 : mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        level_d = level_q + LW'(do_push) - LW'(do_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end
endmodule

module spi_xfer_ctrl #(
    parameter int FIFO_DEPTH   = 8,
    parameter int CS_SETUP_CYC = 50,
    parameter int CS_HOLD_CYC  = 50,
    parameter int LW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          cs_keep,
    input  logic          tx_wr_en,
    input  logic [7:0]    tx_wr_data,
    output logic          tx_full,
    output logic [LW-1:0] tx_level,
    input  logic          rx_rd_en,
    output logic [7:0]    rx_rd_data,
    output logic          rx_empty,
    output logic [LW-1:0] rx_level,
    input  logic          err_clr,
    output logic          tx_overflow,
    output logic          rx_overflow,
    output logic          busy,
    output logic          ss_n,
    output logic          m_start,
    output logic [7:0]    m_tx_data,
    input  logic          m_tx_ready,
    input  logic [7:0]    m_rx_data,
    input  logic          m_done
);
    localparam int CMAX = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_ISSUE, S_WAIT, S_PARK, S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ss_n_q, ss_n_d;
    logic          busy_q, busy_d;
    logic          tx_overflow_q, tx_overflow_d;
    logic          rx_overflow_q, rx_overflow_d;
    logic          tx_empty, rx_full, rx_push;

    spi_xfer_ctrl_fifo #(.DEPTH(FIFO_DEPTH), .W(8), .LW(LW)) u_tx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (tx_wr_en),
        .push_dat (tx_wr_data),
        .pop      (m_start),
        .head_dat (m_tx_data),
        .level    (tx_level),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    spi_xfer_ctrl_fifo #(.DEPTH(FIFO_DEPTH), .W(8), .LW(LW)) u_rx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (rx_push),
        .push_dat (m_rx_data),
        .pop      (rx_rd_en),
        .head_dat (rx_rd_data),
        .level    (rx_level),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    // Start is combinational so the byte handed over is the head before the pop.
    assign m_start     = (state_q == S_ISSUE) && m_tx_ready;
    assign rx_push     = (state_q == S_WAIT) && m_done;
    assign ss_n        = ss_n_q;
    assign busy        = busy_q;
    assign tx_overflow = tx_overflow_q;
    assign rx_overflow = rx_overflow_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:  if (enable && !tx_empty) state_d = S_SETUP;
            S_SETUP: begin
                if (cnt_q == CW'(CS_SETUP_CYC - 1)) state_d = S_ISSUE;
                else                                cnt_d   = cnt_q + 1'b1;
            end
            S_ISSUE: if (m_tx_ready) state_d = S_WAIT;
            S_WAIT: begin
                if (m_done) begin
                    if (enable && !tx_empty)    state_d = S_ISSUE;
                    else if (enable && cs_keep) state_d = S_PARK;
                    else                        state_d = S_HOLD;
                end
            end
            S_PARK: begin
                if (enable && !tx_empty)     state_d = S_ISSUE;
                else if (!enable || !cs_keep) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (cnt_q == CW'(CS_HOLD_CYC - 1)) state_d = S_IDLE;
                else                               cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // Delay counters always start from zero on state entry.
        if (state_d != state_q) cnt_d = '0;

        ss_n_d = (state_d == S_IDLE);
        busy_d = (state_d != S_IDLE);

        tx_overflow_d = tx_overflow_q;
        if (err_clr)            tx_overflow_d = 1'b0;
        if (tx_wr_en && tx_full) tx_overflow_d = 1'b1;

        rx_overflow_d = rx_overflow_q;
        if (err_clr)            rx_overflow_d = 1'b0;
        if (rx_push && rx_full) rx_overflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            ss_n_q        <= 1'b1;
            busy_q        <= 1'b0;
            tx_overflow_q <= 1'b0;
            rx_overflow_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ss_n_q        <= ss_n_d;
            busy_q        <= busy_d;
            tx_overflow_q <= tx_overflow_d;
            rx_overflow_q <= rx_overflow_d;
        end
    end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a loopback byte-engine model.
module tb_spi_xfer_ctrl;
    localparam int DEPTH    = 8;
    localparam int SETUP    = 4;
    localparam int HOLD     = 3;
    localparam int BYTE_CYC = 4;
    localparam int LW       = 4;

    logic          clk = 1'b0;
    logic          reset, enable, cs_keep, tx_wr_en, rx_rd_en, err_clr;
    logic [7:0]    tx_wr_data;
    logic          tx_full, rx_empty, tx_overflow, rx_overflow, busy, ss_n, m_start;
    logic [LW-1:0] tx_level, rx_level;
    logic [7:0]    rx_rd_data, m_tx_data, m_rx_data;
    logic          m_tx_ready, m_done;

    int nerr = 0;
    int nchk = 0;

    spi_xfer_ctrl #(
        .FIFO_DEPTH(DEPTH), .CS_SETUP_CYC(SETUP), .CS_HOLD_CYC(HOLD), .LW(LW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .cs_keep(cs_keep),
        .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_full(tx_full), .tx_level(tx_level),
        .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data), .rx_empty(rx_empty), .rx_level(rx_level),
        .err_clr(err_clr), .tx_overflow(tx_overflow), .rx_overflow(rx_overflow),
        .busy(busy), .ss_n(ss_n), .m_start(m_start), .m_tx_data(m_tx_data),
        .m_tx_ready(m_tx_ready), .m_rx_data(m_rx_data), .m_done(m_done)
    );

    always #5 clk = ~clk;

    // Loopback byte engine: done pulse BYTE_CYC+1 cycles after start, echoing the sent byte.
    logic [7:0] eng_dat;
    int         eng_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_tx_ready <= 1'b1;
            m_done     <= 1'b0;
            m_rx_data  <= 8'h00;
            eng_dat    <= 8'h00;
            eng_cnt    <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_start) begin
                eng_dat    <= m_tx_data;
                eng_cnt    <= BYTE_CYC;
                m_tx_ready <= 1'b0;
            end else if (eng_cnt == 1) begin
                eng_cnt    <= 0;
                m_done     <= 1'b1;
                m_rx_data  <= eng_dat;
                m_tx_ready <= 1'b1;
            end else if (eng_cnt > 1) begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    int   n_start = 0, n_fall = 0, n_rise = 0, n_low = 0;
    logic ss_prev = 1'b1;
    always @(negedge clk) begin
        if (m_start === 1'b1) n_start++;
        if (ss_n === 1'b0) n_low++;
        if (ss_prev === 1'b1 && ss_n === 1'b0) n_fall++;
        if (ss_prev === 1'b0 && ss_n === 1'b1) n_rise++;
        ss_prev = ss_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] b);
        tx_wr_en   = 1'b1;
        tx_wr_data = b;
        @(negedge clk);
        tx_wr_en   = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, rx_rd_data, exp);
        rx_rd_en = 1'b1;
        @(negedge clk);
        rx_rd_en = 1'b0;
    endtask

    task automatic wait_busy(input int budget);
        int k = 0;
        while (busy !== 1'b1 && k < budget) begin @(negedge clk); k++; end
        chk("busy_timeout", busy, 1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin @(negedge clk); k++; end
        chk("idle_timeout", busy, 0);
        @(negedge clk);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        int b_start, b_fall, b_low, b_rise, k, seen;
        reset = 1'b1; enable = 1'b0; cs_keep = 1'b0; tx_wr_en = 1'b0;
        tx_wr_data = 8'h00; rx_rd_en = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ss_n", ss_n, 1);
        chk("rst_m_start", m_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_rx_level", rx_level, 0);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_rx_empty", rx_empty, 1);
        chk("rst_rx_data", rx_rd_data, 8'h00);
        chk("rst_flags", {tx_overflow, rx_overflow}, 0);

        // Basic 3-byte loopback burst.
        enable = 1'b1;
        b_start = n_start; b_fall = n_fall; b_low = n_low;
        wr(8'hA5); wr(8'h3C); wr(8'hFF);
        wait_idle(500);
        chk("b1_starts", n_start - b_start, 3);
        chk("b1_ss_falls", n_fall - b_fall, 1);
        chk("b1_ss_low_cycles", n_low - b_low, SETUP + 3 * (BYTE_CYC + 2) + HOLD);
        chk("b1_tx_level", tx_level, 0);
        chk("b1_rx_level", rx_level, 3);
        pop_chk("b1_rx0", 8'hA5);
        pop_chk("b1_rx1", 8'h3C);
        pop_chk("b1_rx2", 8'hFF);
        chk("b1_rx_empty", rx_empty, 1);

        // TX overflow while disabled.
        enable = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr(8'(i));
            if (i == 7) begin
                chk("ovf_tx_full8", tx_full, 1);
                chk("ovf_tx_level8", tx_level, 8);
                chk("ovf_flag_before", tx_overflow, 0);
            end
        end
        chk("ovf_tx_level9", tx_level, 8);
        chk("ovf_flag_set", tx_overflow, 1);
        chk("ovf_idle_disabled", busy, 0);
        enable = 1'b1;
        wait_busy(20);
        wait_idle(500);
        chk("ovf_rx_level", rx_level, 8);
        chk("ovf_rx_flag", rx_overflow, 0);
        for (int i = 0; i < 8; i++) pop_chk("ovf_rx_byte", 8'(i));
        chk("ovf_rx_empty", rx_empty, 1);
        pulse_err_clr();
        chk("ovf_err_clr", tx_overflow, 0);

        // RX overflow: 9 bytes, no reads.
        for (int i = 0; i < 5; i++) wr(8'(i));
        repeat (20) @(negedge clk);
        for (int i = 5; i < 9; i++) wr(8'(i));
        wait_idle(1000);
        chk("rxo_level", rx_level, 8);
        chk("rxo_flag", rx_overflow, 1);
        chk("rxo_tx_flag", tx_overflow, 0);
        pop_chk("rxo_head0", 8'h00);
        chk("rxo_level7", rx_level, 7);
        chk("rxo_head1", rx_rd_data, 8'h01);
        for (int i = 1; i < 8; i++) pop_chk("rxo_drain", 8'(i));
        chk("rxo_empty", rx_empty, 1);
        pulse_err_clr();
        chk("rxo_err_clr", rx_overflow, 0);

        // cs_keep: ss_n held low across a long gap.
        cs_keep = 1'b1;
        b_rise = n_rise;
        wr(8'h11);
        wait_busy(20);
        repeat (2000) @(negedge clk);
        chk("keep_ss_low", ss_n, 0);
        chk("keep_busy", busy, 1);
        wr(8'h22);
        repeat (30) @(negedge clk);
        chk("keep_ss_low2", ss_n, 0);
        chk("keep_no_rise", n_rise - b_rise, 0);
        chk("keep_rx_level", rx_level, 2);
        pop_chk("keep_rx0", 8'h11);
        pop_chk("keep_rx1", 8'h22);
        cs_keep = 1'b0;
        k = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ss_n === 1'b1) break;
            k++;
        end
        chk("keep_hold_cycles", k, HOLD);
        chk("keep_ss_high", ss_n, 1);

        // enable dropped during byte 2 of 4.
        enable = 1'b0;
        wr(8'h5A); wr(8'hC3); wr(8'h96); wr(8'h69);
        chk("drop_tx_level4", tx_level, 4);
        b_fall = n_fall;
        enable = 1'b1;
        seen = 0; k = 0;
        while (seen < 2 && k < 300) begin
            @(negedge clk);
            k++;
            if (m_start === 1'b1) seen++;
        end
        enable = 1'b0;
        chk("drop_seen_starts", seen, 2);
        wait_idle(200);
        chk("drop_rx_level", rx_level, 2);
        chk("drop_tx_level", tx_level, 2);
        chk("drop_falls", n_fall - b_fall, 1);
        pop_chk("drop_rx0", 8'h5A);
        pop_chk("drop_rx1", 8'hC3);
        b_fall = n_fall;
        enable = 1'b1;
        wait_busy(20);
        wait_idle(500);
        chk("drop_new_setup", n_fall - b_fall, 1);
        chk("drop_tx_drained", tx_level, 0);
        pop_chk("drop_rx2", 8'h96);
        pop_chk("drop_rx3", 8'h69);

        // Reset during WAIT.
        wr(8'h77); wr(8'h88); wr(8'h99);
        seen = 0; k = 0;
        while (seen < 1 && k < 100) begin
            @(negedge clk);
            k++;
            if (m_start === 1'b1) seen++;
        end
        chk("rstw_first_start", seen, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstw_ss_n", ss_n, 1);
        chk("rstw_m_start", m_start, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_tx_level", tx_level, 0);
        chk("rstw_rx_level", rx_level, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_start === 1'b1) seen++;
        end
        chk("rstw_no_start", seen, 0);
        chk("rstw_idle", busy, 0);
        wr(8'h44);
        wait_busy(20);
        wait_idle(200);
        chk("rstw_rx_level", rx_level, 1);
        pop_chk("rstw_rx0", 8'h44);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
